// File: rtl/usb_upload_framer_if.sv
// Upload-path bundle: packet request, payload source and framed byte stream.
// The master drives requests and payload; the framer is the slave.
interface usb_upload_framer_if;
  logic        pkt_start;
  logic [7:0]  pkt_cmd;
  logic [15:0] pkt_len;
  logic        pkt_ready;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic        usb_upload_afull;
  logic [7:0]  usb_upload_data;
  logic        usb_upload_valid;
  logic        pkt_done;
  logic        pkt_err;

  modport master (
    output pkt_start,
    output pkt_cmd,
    output pkt_len,
    output src_data,
    output src_valid,
    output usb_upload_afull,
    input  pkt_ready,
    input  src_ready,
    input  usb_upload_data,
    input  usb_upload_valid,
    input  pkt_done,
    input  pkt_err
  );

  modport slave (
    input  pkt_start,
    input  pkt_cmd,
    input  pkt_len,
    input  src_data,
    input  src_valid,
    input  usb_upload_afull,
    output pkt_ready,
    output src_ready,
    output usb_upload_data,
    output usb_upload_valid,
    output pkt_done,
    output pkt_err
  );
endinterface

// File: rtl/usb_upload_framer.sv
// USB CDC upload framer: HDR0 HDR1 CMD LENH LENL payload CSUM.
// Emits registered bytes one per non-afull cycle; pads on source stall.
module usb_upload_framer #(
  parameter logic [7:0]  HDR0    = 8'hAA,
  parameter logic [7:0]  HDR1    = 8'h44,
  parameter logic [15:0] TIMEOUT = 16'd60000
) (
  input logic                clk,
  input logic                rst,
  usb_upload_framer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_CMD,
    ST_LENH,
    ST_LENL,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cmd;
  logic [15:0] r_len;
  logic [15:0] r_rem;
  logic [7:0]  r_sum;
  logic [15:0] r_stall;
  logic        r_err;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_done;

  state_t      w_state_n;
  logic [7:0]  w_cmd_n;
  logic [15:0] w_len_n;
  logic [15:0] w_rem_n;
  logic [7:0]  w_sum_n;
  logic [15:0] w_stall_n;
  logic        w_err_n;
  logic [7:0]  w_data_n;
  logic        w_valid_n;
  logic        w_done_n;
  logic        w_emit;
  logic        w_timed;
  logic        w_src_ready;

  assign w_emit      = !bus.usb_upload_afull;
  assign w_timed     = (r_stall == TIMEOUT);
  assign w_src_ready = (r_state == ST_PAYLOAD) && w_emit && !w_timed;

  assign bus.pkt_ready        = (r_state == ST_IDLE);
  assign bus.src_ready        = w_src_ready;
  assign bus.usb_upload_data  = r_data;
  assign bus.usb_upload_valid = r_valid;
  assign bus.pkt_done         = r_done;
  assign bus.pkt_err          = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cmd   <= 8'h00;
      r_len   <= 16'h0000;
      r_rem   <= 16'h0000;
      r_sum   <= 8'h00;
      r_stall <= 16'h0000;
      r_err   <= 1'b0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cmd   <= w_cmd_n;
      r_len   <= w_len_n;
      r_rem   <= w_rem_n;
      r_sum   <= w_sum_n;
      r_stall <= w_stall_n;
      r_err   <= w_err_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cmd_n   = r_cmd;
    w_len_n   = r_len;
    w_rem_n   = r_rem;
    w_sum_n   = r_sum;
    w_stall_n = r_stall;
    w_err_n   = r_err;
    w_data_n  = r_data;
    w_valid_n = 1'b0;
    w_done_n  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.pkt_start) begin
          w_cmd_n   = bus.pkt_cmd;
          w_len_n   = bus.pkt_len;
          w_rem_n   = bus.pkt_len;
          // Header fields are folded in up front.
          w_sum_n   = bus.pkt_cmd
                    + bus.pkt_len[15:8]
                    + bus.pkt_len[7:0];
          w_stall_n = 16'h0000;
          w_err_n   = 1'b0;
          // First header byte leaves on the accept edge.
          if (w_emit) begin
            w_data_n  = HDR0;
            w_valid_n = 1'b1;
            w_state_n = ST_HDR1;
          end else begin
            w_state_n = ST_HDR0;
          end
        end
      end

      ST_HDR0: begin
        if (w_emit) begin
          w_data_n  = HDR0;
          w_valid_n = 1'b1;
          w_state_n = ST_HDR1;
        end
      end

      ST_HDR1: begin
        if (w_emit) begin
          w_data_n  = HDR1;
          w_valid_n = 1'b1;
          w_state_n = ST_CMD;
        end
      end

      ST_CMD: begin
        if (w_emit) begin
          w_data_n  = r_cmd;
          w_valid_n = 1'b1;
          w_state_n = ST_LENH;
        end
      end

      ST_LENH: begin
        if (w_emit) begin
          w_data_n  = r_len[15:8];
          w_valid_n = 1'b1;
          w_state_n = ST_LENL;
        end
      end

      ST_LENL: begin
        if (w_emit) begin
          w_data_n  = r_len[7:0];
          w_valid_n = 1'b1;
          w_state_n = (r_len == 16'h0000) ? ST_CSUM
                                           : ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (w_emit) begin
          if (w_timed) begin
            w_data_n  = 8'h00;
            w_valid_n = 1'b1;
            w_rem_n   = r_rem - 16'd1;
            if (r_rem == 16'd1) w_state_n = ST_CSUM;
          end else if (bus.src_valid) begin
            w_data_n  = bus.src_data;
            w_valid_n = 1'b1;
            w_sum_n   = r_sum + bus.src_data;
            w_rem_n   = r_rem - 16'd1;
            w_stall_n = 16'h0000;
            if (r_rem == 16'd1) w_state_n = ST_CSUM;
          end else begin
            w_stall_n = r_stall + 16'd1;
            if (w_stall_n == TIMEOUT) w_err_n = 1'b1;
          end
        end
      end

      ST_CSUM: begin
        if (w_emit) begin
          w_data_n  = r_sum;
          w_valid_n = 1'b1;
          w_done_n  = 1'b1;
          w_state_n = ST_IDLE;
        end
      end

      default: w_state_n = ST_IDLE;
    endcase
  end

endmodule
